// File: rtl/mm_bus_arbiter.sv
// Two-master round-robin arbiter for the external memory-mapped bus.
// Single-beat request/ack transfers; slow slaves are absorbed via mm_rdy with a timeout.
//
// state | meaning
// IDLE  | no transfer in flight, arbitrating between pending requests
// BUSY  | strobes asserted on the external bus, waiting for mm_rdy or timeout
// ACK   | one-cycle completion pulse to the owning master
module mm_bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,

    output logic          mm_re,
    output logic          mm_we,
    output logic [AW-1:0] mm_addr,
    output logic [DW-1:0] mm_wdata,
    input  logic [DW-1:0] mm_rdata,
    input  logic          mm_rdy,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          last_gnt;
    logic          owner;
    logic          we_q;
    logic [CW-1:0] cnt;

    logic          grant;
    logic          grant_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          timeout_hit;
    logic          beat_done;

    // On a tie the master that did not win last time is served.
    always_comb begin
        grant     = m0_req | m1_req;
        grant_id  = (m0_req & m1_req) ? ~last_gnt : m1_req;
        sel_we    = grant_id ? m1_we    : m0_we;
        sel_addr  = grant_id ? m1_addr  : m0_addr;
        sel_wdata = grant_id ? m1_wdata : m0_wdata;
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
    assign beat_done   = mm_rdy | timeout_hit;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (beat_done) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            we_q     <= 1'b0;
            cnt      <= '0;
            mm_re    <= 1'b0;
            mm_we    <= 1'b0;
            mm_addr  <= '0;
            mm_wdata <= '0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner    <= grant_id;
                        we_q     <= sel_we;
                        mm_re    <= ~sel_we;
                        mm_we    <= sel_we;
                        mm_addr  <= sel_addr;
                        mm_wdata <= sel_wdata;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (beat_done) begin
                        mm_re    <= 1'b0;
                        mm_we    <= 1'b0;
                        mm_addr  <= '0;
                        mm_wdata <= '0;
                        m0_ack   <= ~owner;
                        m1_ack   <= owner;
                        // rdy on the final count still counts as success
                        m0_err   <= ~owner & ~mm_rdy;
                        m1_err   <= owner & ~mm_rdy;
                        if (!we_q) begin
                            if (owner) m1_rdata <= mm_rdy ? mm_rdata : '0;
                            else       m0_rdata <= mm_rdy ? mm_rdata : '0;
                        end
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ACK: begin
                    m0_ack   <= 1'b0;
                    m0_err   <= 1'b0;
                    m1_ack   <= 1'b0;
                    m1_err   <= 1'b0;
                    last_gnt <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Self-checking bench for mm_bus_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level model of grant order, timeout and read data.
module tb_mm_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mm_re, mm_we, mm_rdy;
    logic [AW-1:0] mm_addr;
    logic [DW-1:0] mm_wdata, mm_rdata;
    logic          busy;

    int tests = 0;
    int fails = 0;

    // model state: who won last, and what each master's rdata should hold
    int            exp_last;
    logic [DW-1:0] exp_rd [2];

    mm_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mm_re(mm_re), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_rdata(mm_rdata), .mm_rdy(mm_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        mm_rdy = 0; mm_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_last  = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Entered #1 after a posedge with the DUT in IDLE; returns the same way.
    // rdy_at = BUSY cycle (1-based) in which the slave answers; 0 = never.
    task automatic xfer(input bit r0, input bit r1, input bit we0, input bit we1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input int rdy_at, input logic [DW-1:0] rdv);
        int            win;
        bit            wwe;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            done;
        bit            exp_err;

        win = (r0 && r1) ? (exp_last == 1 ? 0 : 1) : (r1 ? 1 : 0);
        wwe = win ? we1 : we0;
        wa  = win ? a1 : a0;
        wd  = win ? d1 : d0;

        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        mm_rdy = 1'($urandom);
        mm_rdata = 16'($urandom);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_strobes", {mm_re, mm_we}, 0);
        check("idle_addr", mm_addr, 0);

        done = 0;
        for (int k = 1; k <= TIMEOUT && !done; k++) begin
            @(posedge clk); #1;
            mm_rdy   = (k == rdy_at);
            mm_rdata = (k == rdy_at) ? rdv : 16'($urandom);
            m0_addr = 16'($urandom); m0_wdata = 16'($urandom); m0_we = 1'($urandom);
            m1_addr = 16'($urandom); m1_wdata = 16'($urandom); m1_we = 1'($urandom);
            @(negedge clk);
            check("busy_flag", busy, 1);
            check("busy_re", mm_re, !wwe);
            check("busy_we", mm_we, wwe);
            check("busy_addr", mm_addr, wa);
            check("busy_wdata", mm_wdata, wd);
            check("busy_noack", {m0_ack, m1_ack}, 0);
            if (k == rdy_at) done = 1;
        end
        exp_err = !done;
        if (!wwe) exp_rd[win] = exp_err ? '0 : rdv;

        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;
        mm_rdy = 1'($urandom);
        @(negedge clk);
        check("ack_m0", m0_ack, win == 0);
        check("ack_m1", m1_ack, win == 1);
        check("err_m0", m0_err, (win == 0) && exp_err);
        check("err_m1", m1_err, (win == 1) && exp_err);
        check("rdata_m0", m0_rdata, exp_rd[0]);
        check("rdata_m1", m1_rdata, exp_rd[1]);
        check("ack_strobes", {mm_re, mm_we}, 0);
        exp_last = win;
        @(posedge clk); #1;
        mm_rdy = 0;
    endtask

    initial begin
        int nack;
        int ids [4];
        int cyc [4];
        int got0;
        bit seen1;

        do_reset();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_outs", {mm_re, mm_we, m0_ack, m1_ack, m0_err, m1_err}, 0);
        check("rst_bus", {mm_addr, mm_wdata}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        @(posedge clk); #1;

        // single M0 read answered in the first BUSY cycle
        xfer(1, 0, 0, 0, 16'hC004, 16'h0, 16'h0, 16'h0, 1, 16'hBEEF);
        // M1 write with three wait states
        xfer(0, 1, 0, 1, 16'h0, 16'hE000, 16'h0, 16'h1234, 4, 16'h5555);
        // M0 read timeout, then a normal transfer
        xfer(1, 0, 0, 0, 16'hC100, 16'h0, 16'h0, 16'h0, 0, 16'h7777);
        xfer(1, 0, 0, 0, 16'hC102, 16'h0, 16'h0, 16'h0, 2, 16'h2468);
        // rdy exactly on the last allowed BUSY cycle
        xfer(1, 0, 0, 0, 16'hC200, 16'h0, 16'h0, 16'h0, TIMEOUT, 16'hA5A5);

        // contention from reset: both requests held, slave always ready
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 16'hC010; m0_wdata = 16'h0101;
        m1_req = 1; m1_we = 1; m1_addr = 16'hE010; m1_wdata = 16'h0202;
        mm_rdy = 1;
        nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                check("one_ack", m0_ack & m1_ack, 0);
                ids[nack] = m1_ack ? 1 : 0;
                cyc[nack] = c;
                nack++;
                if (nack == 4) begin m0_req = 0; m1_req = 0; end
            end
        end
        check("cont_count", nack, 4);
        if (nack == 4) begin
            for (int i = 0; i < 4; i++) check("cont_order", ids[i], i % 2);
            for (int i = 1; i < 4; i++) check("cont_spacing", cyc[i] - cyc[i-1], 3);
        end
        @(posedge clk); #1;
        mm_rdy = 0;
        exp_last = 1;

        // reset in the middle of an M1 write
        m1_req = 1; m1_we = 1; m1_addr = 16'hE000; m1_wdata = 16'h4321;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("pre_rst_we", mm_we, 1);
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 16'hC300;
        mm_rdy = 1; mm_rdata = 16'h3C3C;
        @(negedge clk);
        check("rst_abort_we", mm_we, 0);
        check("rst_abort_busy", busy, 0);
        check("rst_abort_ack", m1_ack, 0);
        @(posedge clk); #1;
        rst = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        got0 = 0; seen1 = 0;
        for (int c = 0; c < 10 && got0 == 0; c++) begin
            @(negedge clk);
            if (m1_ack) seen1 = 1;
            if (m0_ack) begin
                got0 = 1;
                m0_req = 0; m1_req = 0;
            end
        end
        check("post_rst_m0_first", got0, 1);
        check("post_rst_no_m1", seen1, 0);
        check("post_rst_rdata", m0_rdata, 16'h3C3C);
        exp_rd[0] = 16'h3C3C;
        exp_last = 0;
        @(posedge clk); #1;
        mm_rdy = 0;

        // randomized transfers against the model
        for (int t = 0; t < 40; t++) begin
            int pat;
            int ra;
            pat = $urandom_range(1, 3);
            ra  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2);
            xfer(pat[0], pat[1], 1'($urandom), 1'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 ra, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
